// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions
// and the active-high hex glyph table (bit6=a ... bit0=g).
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam int SEG_W = 7;

  // Glyphs for 0-9, A, b, C, d, E, F; lowercase b/d keep them distinct from 8/0.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  function automatic logic [SEG_W-1:0] seg_pattern(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the register/datapath side and the scan driver, plus the
// display-pin side outputs.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
) ();

  // load is a single-cycle strobe with no back-pressure: the driver always
  // accepts it, and digits_in/dp_in/blank_in need only be valid while load=1.
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;
  logic                    lzb_en;

  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_done;

  modport master (
    output digits_in, dp_in, blank_in, load, lzb_en,
    input  seg_out, dp_out, an_out, frame_done
  );

  modport slave (
    input  digits_in, dp_in, blank_in, load, lzb_en,
    output seg_out, dp_out, an_out, frame_done
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high abcdefg segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = seg_pattern(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with frame-synchronous buffer update,
// leading-zero blanking and a one-cycle anode dead time per digit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  localparam logic [SEG_W-1:0]      SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  // Scan counters
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          frame_end;

  // Pending and active display buffers
  logic [DW-1:0]         pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DW-1:0]         act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;

  // Output registers
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;

  // Per-slot selection and decode
  logic [NUM_DIGITS-1:0] zero_blank;
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic [SEG_W-1:0]      dec_seg;
  logic                  lit;

  always_comb begin
    pre_d     = pre_q + PW'(1);
    idx_d     = idx_q;
    frame_end = (pre_q == PRE_LAST) && (idx_q == IDX_LAST);
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // A load on the boundary cycle bypasses pending so it lands in the very
  // next frame instead of waiting a whole extra frame.
  always_comb begin
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_valid_d  = pend_valid_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;
    if (frame_end) begin
      pend_valid_d = 1'b0;
      if (bus.load) begin
        act_digits_d = bus.digits_in;
        act_dp_d     = bus.dp_in;
        act_blank_d  = bus.blank_in;
      end else if (pend_valid_q) begin
        act_digits_d = pend_digits_q;
        act_dp_d     = pend_dp_q;
        act_blank_d  = pend_blank_q;
      end
    end else if (bus.load) begin
      pend_digits_d = bus.digits_in;
      pend_dp_d     = bus.dp_in;
      pend_blank_d  = bus.blank_in;
      pend_valid_d  = 1'b1;
    end
  end

  // Zero-blanking runs down from the most significant digit; digit 0 is exempt.
  always_comb begin
    logic run;
    zero_blank = '0;
    run        = bus.lzb_en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run           = run && (act_digits_q[4*i +: 4] == 4'h0);
      zero_blank[i] = run;
    end
  end

  always_comb begin
    sel_nib    = 4'h0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib       = act_digits_q[4*i +: 4];
        sel_dp        = act_dp_q[i];
        sel_blank     = act_blank_q[i] | zero_blank[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble_i (sel_nib),
    .seg_o    (dec_seg)
  );

  // Prescaler 0 is the dead-time cycle that stops ghosting between digits.
  always_comb begin
    lit  = (pre_q != '0) && !sel_blank;
    an_d = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    fd_d  = frame_end;
    if (lit) begin
      an_d  = (AN_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~dec_seg : dec_seg;
      dp_d  = (SEG_ACTIVE_LOW != 0) ? ~sel_dp : sel_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= '0;
      idx_q         <= '0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_valid_q  <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '0;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      an_q          <= AN_OFF;
      fd_q          <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_valid_q  <= pend_valid_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      fd_q          <= fd_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.an_out     = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-cycle slots, active-low pins.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S1  = 7'b1001111;
  localparam logic [6:0] S2  = 7'b0010010;
  localparam logic [6:0] S3  = 7'b0000110;
  localparam logic [6:0] S5  = 7'b0100100;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SF  = 7'b0111000;
  localparam logic [6:0] OFF = 7'b1111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int err_cnt = 0;
  int chk_cnt = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus_if ();

  seg7_scan_driver #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    bus_if.digits_in = d;
    bus_if.dp_in     = dp;
    bus_if.blank_in  = bl;
    bus_if.load      = 1'b1;
    tick();
    bus_if.load      = 1'b0;
  endtask

  task automatic wait_fd();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus_if.frame_done === 1'b1) found = 1'b1;
    end
    check("frame_done_seen", {31'd0, found}, 32'd1);
  endtask

  // Checks one whole frame starting just after a frame_done sample; optionally
  // pulses load with new_d at cycle load_at (1..16) of the frame.
  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] lit_mask, input logic [3:0] dp_mask,
                             input int load_at, input logic [15:0] new_d);
    logic [6:0] sp [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int s, k;
    sp[0] = s0; sp[1] = s1; sp[2] = s2; sp[3] = s3;
    for (int c = 1; c <= 16; c++) begin
      s = (c - 1) / 4;
      k = (c - 1) % 4;
      if (c == load_at) begin
        bus_if.digits_in = new_d;
        bus_if.dp_in     = 4'b0000;
        bus_if.blank_in  = 4'b0000;
        bus_if.load      = 1'b1;
      end
      tick();
      bus_if.load = 1'b0;
      exp_an  = 4'b1111;
      exp_seg = OFF;
      exp_dp  = 1'b1;
      if (k != 0 && lit_mask[s]) begin
        exp_an     = 4'b1111;
        exp_an[s]  = 1'b0;
        exp_seg    = sp[s];
        exp_dp     = ~dp_mask[s];
      end
      check($sformatf("s%0d_c%0d_an", s, c), {28'd0, bus_if.an_out}, {28'd0, exp_an});
      check($sformatf("s%0d_c%0d_seg", s, c), {25'd0, bus_if.seg_out}, {25'd0, exp_seg});
      check($sformatf("s%0d_c%0d_dp", s, c), {31'd0, bus_if.dp_out}, {31'd0, exp_dp});
      check($sformatf("c%0d_frame_done", c), {31'd0, bus_if.frame_done}, {31'd0, (c == 16)});
    end
  endtask

  initial begin
    logic seen;
    bus_if.digits_in = '0;
    bus_if.dp_in     = '0;
    bus_if.blank_in  = '0;
    bus_if.load      = 1'b0;
    bus_if.lzb_en    = 1'b0;

    repeat (3) tick();
    check("por_an", {28'd0, bus_if.an_out}, 32'hF);
    check("por_seg", {25'd0, bus_if.seg_out}, 32'h7F);
    rst_n = 1'b1;

    // Get the display lit, queue a pending load, then reset mid-slot.
    do_load(16'h8888, 4'b0000, 4'b0000);
    wait_fd();
    tick();
    tick();
    check("prereset_an", {28'd0, bus_if.an_out}, 32'hE);
    do_load(16'h1234, 4'b1111, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_an", {28'd0, bus_if.an_out}, 32'hF);
    check("rst_seg", {25'd0, bus_if.seg_out}, 32'h7F);
    check("rst_dp", {31'd0, bus_if.dp_out}, 32'd1);
    check("rst_fd", {31'd0, bus_if.frame_done}, 32'd0);
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus_if.an_out !== 4'b1111) seen = 1'b1;
    end
    check("post_rst_first_an", {28'd0, bus_if.an_out}, 32'hE);
    // Cleared active buffer shows zeros; the pre-reset pending load is gone.
    wait_fd();
    check_frame(S0, S0, S0, S0, 4'b1111, 4'b0000, 0, 16'h0);

    // Basic display with a decimal point on digit 2.
    do_load(16'h12AF, 4'b0100, 4'b0000);
    wait_fd();
    check_frame(SF, SA, S2, S1, 4'b1111, 4'b0100, 0, 16'h0);

    // Leading-zero blanking.
    bus_if.lzb_en = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_fd();
    check_frame(S0, S5, OFF, OFF, 4'b0011, 4'b0000, 0, 16'h0);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_fd();
    check_frame(S0, OFF, OFF, OFF, 4'b0001, 4'b0000, 0, 16'h0);
    bus_if.lzb_en = 1'b0;

    // Tear-free update: mid-frame load, then a load on the boundary cycle.
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_fd();
    check_frame(S2, S2, S2, S2, 4'b1111, 4'b0000, 6, 16'h1111);
    check_frame(S1, S1, S1, S1, 4'b1111, 4'b0000, 16, 16'h3333);
    check_frame(S3, S3, S3, S3, 4'b1111, 4'b0000, 0, 16'h0);
    check_frame(S3, S3, S3, S3, 4'b1111, 4'b0000, 0, 16'h0);

    // Forced blank of digit 1.
    do_load(16'h8888, 4'b0000, 4'b0010);
    wait_fd();
    check_frame(S8, OFF, S8, S8, 4'b1101, 4'b0000, 0, 16'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
